// File: rtl/mss_pkg.sv
// Shared MSS scan definitions: chain geometry and the scan driver state encoding.
package mss_pkg;
  localparam int MSS_CHAIN_LEN = 8;
  localparam int MSS_CLUSTER_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/mss_piso_sipo.sv
// Pattern serialiser (parallel load, MSB out) paired with a serial capture
// register that collects the chain's previous contents.
module mss_piso_sipo #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 shift,
  input  logic                 si,
  output logic                 so,
  output logic [CHAIN_LEN-1:0] cap_next
);
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] rsp_sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_sh <= '0;
      rsp_sh <= '0;
    end else if (load) begin
      pat_sh <= load_data;
    end else if (shift) begin
      pat_sh <= pat_sh << 1;
      rsp_sh <= cap_next;
    end
  end

  assign so       = pat_sh[CHAIN_LEN-1];
  // Includes the bit on the chain output this cycle, so the final capture needs no extra shift.
  assign cap_next = {rsp_sh[CHAIN_LEN-2:0], si};
endmodule

// File: rtl/mss_scan_driver.sv
// MSS scan chain driver: accepts a pattern, shifts it MSB-first into the chain and
// returns the chain's previous contents as a response.
module mss_scan_driver
  import mss_pkg::*;
#(
  parameter int CHAIN_LEN = MSS_CHAIN_LEN,
  parameter int CLUSTER_W = MSS_CLUSTER_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CLUSTER_W-1:0] pat_cluster,
  input  logic                 abort,
  output logic                 chain_enable,
  output logic                 chain_si,
  input  logic                 chain_so,
  output logic [CLUSTER_W-1:0] chain_cluster_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic [CLUSTER_W-1:0] rsp_cluster,
  output logic                 busy,
  output logic [CNT_W-1:0]     pat_count
);
  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 rdy_en;
  logic                 accept;
  logic                 rsp_hs;
  logic                 shifting;
  logic [CHAIN_LEN-1:0] cap_next;

  assign shifting     = (state == SHIFT);
  assign chain_enable = shifting;
  assign rsp_valid    = (state == RESP);
  assign busy         = (state != IDLE);
  // rdy_en keeps pat_ready low while reset is asserted and releases it one cycle later.
  assign pat_ready    = rdy_en && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign accept       = pat_valid && pat_ready;
  assign rsp_hs       = rsp_valid && rsp_ready;

  mss_piso_sipo #(.CHAIN_LEN(CHAIN_LEN)) u_sh (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .load_data (pat_data),
    .shift     (shifting),
    .si        (chain_so),
    .so        (chain_si),
    .cap_next  (cap_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      rdy_en            <= 1'b0;
      chain_cluster_sel <= '0;
      rsp_data          <= '0;
      rsp_cluster       <= '0;
      pat_count         <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        chain_cluster_sel <= pat_cluster;
        cnt               <= '0;
      end
      case (state)
        IDLE:  if (accept) state <= SHIFT;
        SHIFT: begin
          // abort wins over the final-shift transition
          if (abort) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state       <= RESP;
              rsp_data    <= cap_next;
              rsp_cluster <= chain_cluster_sel;
              pat_count   <= pat_count + 1'b1;
            end
          end
        end
        RESP:    if (rsp_hs) state <= accept ? SHIFT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mss_scan_driver.sv
// Scoreboarded bench for mss_scan_driver driving a behavioural MSS scan chain.
module tb_mss_scan_driver;
  import mss_pkg::*;
  localparam int N  = 8;
  localparam int CW = 2;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pat_valid = 1'b0;
  logic          pat_ready;
  logic [N-1:0]  pat_data = '0;
  logic [CW-1:0] pat_cluster = '0;
  logic          abort = 1'b0;
  logic          chain_enable, chain_si, chain_so;
  logic [CW-1:0] chain_cluster_sel;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [N-1:0]  rsp_data;
  logic [CW-1:0] rsp_cluster;
  logic          busy;
  logic [NW-1:0] pat_count;

  mss_scan_driver #(.CHAIN_LEN(N), .CLUSTER_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_cluster(pat_cluster), .abort(abort),
    .chain_enable(chain_enable), .chain_si(chain_si), .chain_so(chain_so),
    .chain_cluster_sel(chain_cluster_sel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cluster(rsp_cluster), .busy(busy), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for mss_block: one chain, cleared by reset.
  logic [N-1:0] chain;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          chain <= '0;
    else if (chain_enable) chain <= {chain[N-2:0], chain_si};
  end
  assign chain_so = chain[N-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [N-1:0]  d;
    logic [CW-1:0] c;
  } exp_t;
  exp_t         sb[$];
  logic [N-1:0] exp_chain = '0;
  int           nvec = 0;
  int           nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [CW-1:0] c, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    pat_valid = 1'b1; pat_data = d; pat_cluster = c;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (pat_ready) begin ok = 1'b1; break; end
      step();
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    acc_cyc = cyc;
    sb.push_back('{d: exp_chain, c: c});
    exp_chain = d;
    step();
    pat_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      step();
    end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Response monitor: sampled well after the drivers settle, before the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_cluster", 32'(rsp_cluster), 32'(e.c));
      end
    end
  end

  initial begin
    int a0, a1, a2, tmp;
    logic [N-1:0]  p, old;
    logic [NW-1:0] cnt0;

    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'(chain_enable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pat_ready", 32'(pat_ready), 32'd0);
    chk("rst_pat_count", 32'(pat_count), 32'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(pat_ready), 32'd1);

    // 1: serialisation order and latency
    p = 8'hA5;
    send(p, 2'd2, tmp);
    for (int k = 0; k < N; k++) begin
      chk("shift_enable", 32'(chain_enable), 32'd1);
      chk("shift_si", 32'(chain_si), 32'(p[N-1-k]));
      chk("shift_sel", 32'(chain_cluster_sel), 32'd2);
      step();
    end
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp_data", 32'(rsp_data), 32'h00);
    chk("lat_rsp_cluster", 32'(rsp_cluster), 32'd2);
    chk("lat_pat_count", 32'(pat_count), 32'd1);
    step();

    // 2: chain history comes back one pattern late
    send(8'h3C, 2'd2, tmp); wait_rsp();
    chk("hist_a5", 32'(rsp_data), 32'hA5);
    step();
    send(8'h00, 2'd2, tmp); wait_rsp();
    chk("hist_3c", 32'(rsp_data), 32'h3C);
    step();

    // 3: back-pressure holds the response
    rsp_ready = 1'b0;
    send(8'h96, 2'd1, tmp); wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h00);
      chk("hold_cluster", 32'(rsp_cluster), 32'd1);
      chk("hold_pat_ready", 32'(pat_ready), 32'd0);
      chk("hold_enable", 32'(chain_enable), 32'd0);
      step();
    end
    rsp_ready = 1'b1;

    // 4: accept coincides with the response handshake; 9-cycle period
    send(8'h5E, 2'd3, a0);
    chk("b2b_resume", 32'(chain_enable), 32'd1);
    send(8'h81, 2'd0, a1);
    chk("b2b_resume", 32'(chain_enable), 32'd1);
    send(8'hE7, 2'd1, a2);
    chk("b2b_period", 32'(a1 - a0), 32'd9);
    chk("b2b_period", 32'(a2 - a1), 32'd9);
    wait_rsp(); step();
    wait_idle();

    // 5: abort on the 4th shift cycle
    old = exp_chain;
    p = 8'hC3;
    cnt0 = pat_count;
    send(p, 2'd1, tmp);
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    void'(sb.pop_back());
    exp_chain = (old << 4) | (p >> 4);
    for (int i = 0; i < 10; i++) begin
      chk("abort_enable", 32'(chain_enable), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      step();
    end
    chk("abort_pat_ready", 32'(pat_ready), 32'd1);
    chk("abort_count", 32'(pat_count), 32'(cnt0));
    send(8'h5A, 2'd2, tmp); wait_rsp(); step();
    wait_idle();

    // 6: async reset mid-shift
    send(8'h77, 2'd3, tmp);
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("arst_enable", 32'(chain_enable), 32'd0);
    chk("arst_si", 32'(chain_si), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_pat_ready", 32'(pat_ready), 32'd0);
    chk("arst_count", 32'(pat_count), 32'd0);
    chk("arst_sel", 32'(chain_cluster_sel), 32'd0);
    chk("arst_rsp_data", 32'(rsp_data), 32'd0);
    sb.delete();
    exp_chain = '0;
    step();
    reset_n = 1'b1;
    step();
    chk("arst_release_ready", 32'(pat_ready), 32'd1);
    send(8'hFF, 2'd0, tmp); wait_rsp();
    chk("arst_ff_rsp", 32'(rsp_data), 32'h00);
    step();
    wait_idle();

    // 7: counter wrap
    force dut.pat_count = 16'hFFFF;
    step();
    release dut.pat_count;
    send(8'h11, 2'd1, tmp); wait_rsp();
    chk("count_wrap", 32'(pat_count), 32'h0000);
    step();
    wait_idle();
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
